// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache:
// address field layout, line geometry and controller state encoding.
package dcache_pkg;

  localparam int LINES    = 32;
  localparam int WORDS    = 8;
  localparam int TAG_W    = 22;
  localparam int IDX_W    = 5;
  localparam int WORD_W   = 3;
  localparam int LINE_W   = 256;
  localparam int WORD_LSB = 2;
  localparam int IDX_LSB  = 5;
  localparam int TAG_LSB  = 10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    WB_GAP    = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

  // Line-aligned byte address for memory transactions.
  function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag,
                                            input logic [IDX_W-1:0] idx);
    return {tag, idx, 5'b0};
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Cache storage: valid/dirty bits (cleared on reset) plus tag and data arrays.
// Reads are asynchronous on the presented index; writes happen on the clock edge.
module dcache_sram
  import dcache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  idx,
  output logic              valid,
  output logic              dirty,
  output logic [TAG_W-1:0]  tag,
  output logic [LINE_W-1:0] line,
  input  logic              word_we,
  input  logic [WORD_W-1:0] word_sel,
  input  logic [31:0]       word_data,
  input  logic              fill_we,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [LINE_W-1:0] fill_data
);

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];

  assign valid = valid_q[idx];
  assign dirty = dirty_q[idx];
  assign tag   = tag_q[idx];
  assign line  = data_q[idx];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (word_we) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Tag and data contents survive reset; only the valid bits gate their use.
  always_ff @(posedge clk_i) begin
    if (fill_we) begin
      tag_q[idx]  <= fill_tag;
      data_q[idx] <= fill_data;
    end else if (word_we) begin
      data_q[idx][{word_sel, 5'b0} +: 32] <= word_data;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller: combinational
// hits, pipeline stall on miss, line writeback/refill over a req/ack memory port.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);

  state_t state;

  logic [TAG_W-1:0]  addr_tag;
  logic [IDX_W-1:0]  addr_idx;
  logic [WORD_W-1:0] addr_word;
  logic              unused_byte_bits;

  logic              line_valid;
  logic              line_dirty;
  logic [TAG_W-1:0]  line_tag;
  logic [LINE_W-1:0] line_data;

  logic hit;
  logic idle_hit;
  logic word_we;
  logic fill_we;

  assign addr_tag         = cpu_addr_i[31:TAG_LSB];
  assign addr_idx         = cpu_addr_i[TAG_LSB-1:IDX_LSB];
  assign addr_word        = cpu_addr_i[IDX_LSB-1:WORD_LSB];
  assign unused_byte_bits = ^cpu_addr_i[WORD_LSB-1:0];

  assign hit      = cpu_req_i & line_valid & (line_tag == addr_tag);
  assign idle_hit = (state == IDLE) & hit;
  assign word_we  = idle_hit & cpu_we_i;
  assign fill_we  = (state == ALLOCATE) & mem_ack_i;

  assign cpu_stall_o = rst_i & cpu_req_i & ~idle_hit;
  assign cpu_rdata_o = hit ? line_data[{addr_word, 5'b0} +: 32] : 32'd0;

  dcache_sram u_sram (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .idx       (addr_idx),
    .valid     (line_valid),
    .dirty     (line_dirty),
    .tag       (line_tag),
    .line      (line_data),
    .word_we   (word_we),
    .word_sel  (addr_word),
    .word_data (cpu_wdata_i),
    .fill_we   (fill_we),
    .fill_tag  (addr_tag),
    .fill_data (mem_rdata_i)
  );

  // Memory-side outputs are registered and only change on state transitions,
  // so they stay stable for the whole transaction until the ack edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req_i && !hit) begin
            mem_req_o <= 1'b1;
            if (line_valid && line_dirty) begin
              state       <= WRITEBACK;
              mem_we_o    <= 1'b1;
              mem_addr_o  <= line_addr(line_tag, addr_idx);
              mem_wdata_o <= line_data;
            end else begin
              state      <= ALLOCATE;
              mem_we_o   <= 1'b0;
              mem_addr_o <= line_addr(addr_tag, addr_idx);
            end
          end
        end
        WRITEBACK: begin
          if (mem_ack_i) begin
            state     <= WB_GAP;
            mem_req_o <= 1'b0;
          end
        end
        WB_GAP: begin
          state      <= ALLOCATE;
          mem_req_o  <= 1'b1;
          mem_we_o   <= 1'b0;
          mem_addr_o <= line_addr(addr_tag, addr_idx);
        end
        ALLOCATE: begin
          if (mem_ack_i) begin
            state     <= IDLE;
            mem_req_o <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          mem_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl: refill, store hit, dirty
// eviction, store miss, reset during refill and stray acks.
module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i;
  logic         cpu_we_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_wdata_i;
  logic [31:0]  cpu_rdata_o;
  logic         cpu_stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_wdata_o;
  logic [255:0] mem_rdata_i;
  logic         mem_ack_i;

  int vectors    = 0;
  int miscompares = 0;
  int stallCycles = 0;

  logic [255:0] line1, line2, line3, line4, line5, onesLine;

  dcache_ctrl dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_rdata_o (cpu_rdata_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic applyStimulus(input logic req, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic ack,
                               input logic [255:0] rdata);
    cpu_req_i   = req;
    cpu_we_i    = we;
    cpu_addr_i  = addr;
    cpu_wdata_i = wdata;
    mem_ack_i   = ack;
    mem_rdata_i = rdata;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    vectors++;
    assert (observed === expected)
      else begin
        miscompares++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  // Advance one clock, tallying stall cycles seen before the edge.
  task automatic cycle();
    if (cpu_stall_o) stallCycles++;
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [255:0] makeLine(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  initial begin
    line1 = makeLine(32'h1111_0000);
    line1[2*32 +: 32] = 32'hDEAD_BEEF;
    line2 = makeLine(32'h2222_0000);
    line3 = makeLine(32'h3333_0000);
    line4 = makeLine(32'h4444_0000);
    line5 = makeLine(32'h5555_0000);
    onesLine = '1;

    // Reset values, with a request present to show stall is forced low.
    rst_i = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h400, 32'd0, 1'b0, '0);
    checkOutput("rst_stall", 256'(cpu_stall_o), 256'(1'b0));
    checkOutput("rst_req", 256'(mem_req_o), 256'(1'b0));
    checkOutput("rst_we", 256'(mem_we_o), 256'(1'b0));
    checkOutput("rst_addr", 256'(mem_addr_o), 256'(32'h0));
    checkOutput("rst_wdata", mem_wdata_o, 256'd0);
    checkOutput("rst_rdata", 256'(cpu_rdata_o), 256'(32'h0));
    applyStimulus(1'b0, 1'b0, 32'h0, 32'd0, 1'b0, '0);
    @(negedge clk_i);
    rst_i = 1'b1;
    cycle();

    // Clean load miss on 0x400, ack on the third request cycle.
    stallCycles = 0;
    applyStimulus(1'b1, 1'b0, 32'h400, 32'd0, 1'b0, '0);
    checkOutput("miss_stall", 256'(cpu_stall_o), 256'(1'b1));
    checkOutput("miss_req_delay", 256'(mem_req_o), 256'(1'b0));
    cycle();
    checkOutput("fill_req", 256'(mem_req_o), 256'(1'b1));
    checkOutput("fill_we", 256'(mem_we_o), 256'(1'b0));
    checkOutput("fill_addr", 256'(mem_addr_o), 256'(32'h400));
    cycle();
    cycle();
    checkOutput("fill_req_hold", 256'(mem_req_o), 256'(1'b1));
    applyStimulus(1'b1, 1'b0, 32'h400, 32'd0, 1'b1, line1);
    cycle();
    applyStimulus(1'b1, 1'b0, 32'h400, 32'd0, 1'b0, '0);
    checkOutput("fill_req_drop", 256'(mem_req_o), 256'(1'b0));
    checkOutput("fill_stall_low", 256'(cpu_stall_o), 256'(1'b0));
    checkOutput("fill_stall_cycles", 256'(stallCycles), 256'(4));
    checkOutput("fill_word0", 256'(cpu_rdata_o), 256'(32'h1111_0000));
    applyStimulus(1'b1, 1'b0, 32'h408, 32'd0, 1'b0, '0);
    checkOutput("hit_word2", 256'(cpu_rdata_o), 256'(32'hDEAD_BEEF));
    checkOutput("hit_stall", 256'(cpu_stall_o), 256'(1'b0));
    applyStimulus(1'b0, 1'b0, 32'h408, 32'd0, 1'b0, '0);
    checkOutput("noreq_rdata", 256'(cpu_rdata_o), 256'(32'h0));

    // Store hit then load back.
    applyStimulus(1'b1, 1'b1, 32'h404, 32'h1234_5678, 1'b0, '0);
    checkOutput("st_hit_stall", 256'(cpu_stall_o), 256'(1'b0));
    cycle();
    checkOutput("st_hit_noreq", 256'(mem_req_o), 256'(1'b0));
    applyStimulus(1'b1, 1'b0, 32'h404, 32'd0, 1'b0, '0);
    checkOutput("st_hit_readback", 256'(cpu_rdata_o), 256'(32'h1234_5678));
    checkOutput("st_hit_ld_stall", 256'(cpu_stall_o), 256'(1'b0));

    // Dirty conflict: load 0x804 evicts the dirty 0x400 line (Nwb=2, Nal=1).
    stallCycles = 0;
    applyStimulus(1'b1, 1'b0, 32'h804, 32'd0, 1'b0, '0);
    checkOutput("wb_stall", 256'(cpu_stall_o), 256'(1'b1));
    cycle();
    checkOutput("wb_req", 256'(mem_req_o), 256'(1'b1));
    checkOutput("wb_we", 256'(mem_we_o), 256'(1'b1));
    checkOutput("wb_addr", 256'(mem_addr_o), 256'(32'h400));
    checkOutput("wb_word1", 256'(mem_wdata_o[32 +: 32]), 256'(32'h1234_5678));
    checkOutput("wb_word2", 256'(mem_wdata_o[64 +: 32]), 256'(32'hDEAD_BEEF));
    cycle();
    applyStimulus(1'b1, 1'b0, 32'h804, 32'd0, 1'b1, '0);
    cycle();
    applyStimulus(1'b1, 1'b0, 32'h804, 32'd0, 1'b0, '0);
    checkOutput("gap_req_low", 256'(mem_req_o), 256'(1'b0));
    checkOutput("gap_stall", 256'(cpu_stall_o), 256'(1'b1));
    cycle();
    checkOutput("al_req", 256'(mem_req_o), 256'(1'b1));
    checkOutput("al_we", 256'(mem_we_o), 256'(1'b0));
    checkOutput("al_addr", 256'(mem_addr_o), 256'(32'h800));
    applyStimulus(1'b1, 1'b0, 32'h804, 32'd0, 1'b1, line2);
    cycle();
    applyStimulus(1'b1, 1'b0, 32'h804, 32'd0, 1'b0, '0);
    checkOutput("dirty_stall_cycles", 256'(stallCycles), 256'(5));
    checkOutput("dirty_rdata", 256'(cpu_rdata_o), 256'(32'h2222_0001));

    // Store miss on clean index 1: straight to refill, then store completes.
    applyStimulus(1'b1, 1'b1, 32'h1020, 32'hA5A5_A5A5, 1'b0, '0);
    cycle();
    checkOutput("stmiss_we", 256'(mem_we_o), 256'(1'b0));
    checkOutput("stmiss_addr", 256'(mem_addr_o), 256'(32'h1020));
    applyStimulus(1'b1, 1'b1, 32'h1020, 32'hA5A5_A5A5, 1'b1, line3);
    cycle();
    applyStimulus(1'b1, 1'b1, 32'h1020, 32'hA5A5_A5A5, 1'b0, '0);
    checkOutput("stmiss_stall_low", 256'(cpu_stall_o), 256'(1'b0));
    cycle();
    applyStimulus(1'b1, 1'b0, 32'h1020, 32'd0, 1'b0, '0);
    checkOutput("stmiss_readback", 256'(cpu_rdata_o), 256'(32'hA5A5_A5A5));
    applyStimulus(1'b1, 1'b0, 32'h1024, 32'd0, 1'b0, '0);
    checkOutput("stmiss_word1", 256'(cpu_rdata_o), 256'(32'h3333_0001));
    applyStimulus(1'b1, 1'b0, 32'h1820, 32'd0, 1'b0, '0);
    cycle();
    checkOutput("stmiss_wb_we", 256'(mem_we_o), 256'(1'b1));
    checkOutput("stmiss_wb_addr", 256'(mem_addr_o), 256'(32'h1020));
    checkOutput("stmiss_wb_word0", 256'(mem_wdata_o[31:0]), 256'(32'hA5A5_A5A5));
    applyStimulus(1'b1, 1'b0, 32'h1820, 32'd0, 1'b1, '0);
    cycle();
    applyStimulus(1'b1, 1'b0, 32'h1820, 32'd0, 1'b0, '0);
    cycle();
    applyStimulus(1'b1, 1'b0, 32'h1820, 32'd0, 1'b1, line5);
    cycle();
    applyStimulus(1'b1, 1'b0, 32'h1820, 32'd0, 1'b0, '0);
    checkOutput("conflict_rdata", 256'(cpu_rdata_o), 256'(32'h5555_0000));

    // Reset pulse during ALLOCATE abandons the refill.
    applyStimulus(1'b1, 1'b0, 32'h2000, 32'd0, 1'b0, '0);
    cycle();
    checkOutput("rstal_req", 256'(mem_req_o), 256'(1'b1));
    rst_i = 1'b0;
    #1;
    checkOutput("rstal_req_drop", 256'(mem_req_o), 256'(1'b0));
    checkOutput("rstal_stall", 256'(cpu_stall_o), 256'(1'b0));
    #1;
    rst_i = 1'b1;
    #1;
    checkOutput("rstal_remiss", 256'(cpu_stall_o), 256'(1'b1));
    cycle();
    checkOutput("rstal_refetch", 256'(mem_addr_o), 256'(32'h2000));
    applyStimulus(1'b1, 1'b0, 32'h2000, 32'd0, 1'b1, line4);
    cycle();
    applyStimulus(1'b1, 1'b0, 32'h2000, 32'd0, 1'b0, '0);
    checkOutput("rstal_hit", 256'(cpu_rdata_o), 256'(32'h4444_0000));

    // Stray ack in IDLE with no request must not disturb anything.
    applyStimulus(1'b0, 1'b0, 32'h2000, 32'd0, 1'b1, onesLine);
    cycle();
    cycle();
    checkOutput("stray_req", 256'(mem_req_o), 256'(1'b0));
    applyStimulus(1'b1, 1'b0, 32'h2004, 32'd0, 1'b0, '0);
    checkOutput("stray_rdata", 256'(cpu_rdata_o), 256'(32'h4444_0001));
    checkOutput("stray_stall", 256'(cpu_stall_o), 256'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
